// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] PC_STEP    = 32'd4;
    localparam logic [31:0] R15_OFFSET = 32'd8;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO of fetched {instr, pc} entries with a one-cycle flush.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [ENTRY_W-1:0]         i_data,
    input  logic                       i_pop,
    output logic [ENTRY_W-1:0]         o_head,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_rd_ptr;
    logic [AW-1:0]      r_wr_ptr;
    logic [AW:0]        r_count;
    logic               w_pop;
    logic               w_push;

    assign w_pop  = i_pop && (r_count != '0);
    // A full FIFO may still accept a push when the head leaves in the same cycle.
    assign w_push = i_push && !i_flush && ((r_count != FULL) || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: owns the fetch PC, issues one-outstanding imem reads, buffers words for decode.
// Optional IFETCH_PERF_EN adds saturating stall_cnt / flush_cnt outputs.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus8,
    output logic        InstrValid,
    input  logic        InstrReady,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam int            CW   = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_state_t  r_state;
    fetch_state_t  w_state_next;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   w_fetch_pc_next;
    logic [31:0]   r_inflight_pc;
    logic [31:0]   w_inflight_pc_next;
    logic [31:0]   w_target;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count;
    fetch_entry_t  w_push_entry;
    fetch_entry_t  w_head_entry;
    logic          w_unused_redirect_lsb;

    assign w_target              = {RedirectPC[31:2], 2'b00};
    assign w_unused_redirect_lsb = ^RedirectPC[1:0];

    always_comb begin
        w_state_next       = r_state;
        w_fetch_pc_next    = r_fetch_pc;
        w_inflight_pc_next = r_inflight_pc;
        w_push             = 1'b0;
        imem_req           = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_next = FETCH;
            end
            FETCH: begin
                imem_req = (w_count != FULL);
                if (imem_req && imem_gnt) begin
                    w_inflight_pc_next = r_fetch_pc;
                    w_fetch_pc_next    = r_fetch_pc + PC_STEP;
                    w_state_next       = Redirect ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    w_push       = !Redirect;
                    w_state_next = FETCH;
                end else if (Redirect) begin
                    w_state_next = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    w_state_next = FETCH;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
        // A redirect overrides any sequential PC advance in the same cycle.
        if (Redirect) begin
            w_fetch_pc_next = w_target;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_fetch_pc    <= {RESET_PC[31:2], 2'b00};
            r_inflight_pc <= '0;
        end else begin
            r_state       <= w_state_next;
            r_fetch_pc    <= w_fetch_pc_next;
            r_inflight_pc <= w_inflight_pc_next;
        end
    end

    assign w_push_entry.instr = imem_rdata;
    assign w_push_entry.pc    = r_inflight_pc;

    ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_flush (Redirect),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head_entry),
        .o_count (w_count)
    );

    assign imem_addr  = r_fetch_pc;
    assign InstrValid = (w_count != '0);
    assign w_pop      = InstrValid && InstrReady;
    assign Instr      = InstrValid ? w_head_entry.instr : 32'd0;
    assign PC         = InstrValid ? w_head_entry.pc    : 32'd0;
    assign PCPlus8    = PC + R15_OFFSET;

`ifdef IFETCH_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if ((r_state != IDLE) && !InstrValid && (r_stall_cnt != 32'hFFFFFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (Redirect && (r_flush_cnt != 32'hFFFFFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule
